// File: rtl/brick_dispatcher.sv
// rtl/brick_dispatcher.sv - captures one zero-free brick and streams its (neuron, offset) pairs

module brick_dispatcher (
    input  logic         clk,
    input  logic         rst,
    input  logic         brick_valid,
    input  logic [255:0] brick_data,
    input  logic [63:0]  brick_off,
    output logic         brick_ack,
    output logic         nz_valid,
    input  logic         nz_ready,
    output logic [15:0]  nz_data,
    output logic [3:0]   nz_off,
    output logic         nz_last,
    output logic [4:0]   nz_count,
    output logic         brick_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [255:0]   buf_data;
    logic [63:0]    buf_off;
    logic [3:0]     idx;
    logic [4:0]     count;
    logic [4:0]     first_zero;
    logic           capture;
    logic           at_last;
    logic           accept;

    // Count of leading non-zero slots: the encoder packs non-zeros first, so
    // anything after the first zero slot is stale and must not be sent.
    always_comb begin
        first_zero = 5'd16;
        for (int k = 15; k >= 0; k--) begin
            if (brick_data[16*k +: 16] == 16'd0) begin
                first_zero = 5'(k);
            end
        end
    end

    assign capture = (state == IDLE) && brick_valid;
    assign at_last = ({1'b0, idx} == (count - 5'd1));
    assign accept  = (state == SEND) && nz_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; waiting for the flag to fall keeps a held brick from being re-dispatched
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (brick_valid) begin
                    state_next = (first_zero == 5'd0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (nz_ready && at_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!brick_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Brick buffers, slot index, count and the capture acknowledge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data  <= '0;
            buf_off   <= '0;
            idx       <= '0;
            count     <= '0;
            brick_ack <= 1'b0;
        end else begin
            brick_ack <= capture;
            if (capture) begin
                buf_data <= brick_data;
                buf_off  <= brick_off;
                count    <= first_zero;
                idx      <= '0;
            end else if (accept && !at_last) begin
                idx <= idx + 4'd1;
            end
        end
    end

    // Stream outputs are pure state decode so they never depend on nz_ready
    always_comb begin
        nz_valid = (state == SEND);
        nz_data  = 16'd0;
        nz_off   = 4'd0;
        nz_last  = 1'b0;
        if (state == SEND) begin
            nz_data = buf_data[{idx, 4'b0000} +: 16];
            nz_off  = buf_off[{idx, 2'b00} +: 4];
            nz_last = at_last;
        end
    end

    assign nz_count   = count;
    assign brick_done = (state == DONE);

endmodule

// File: tb/tb_brick_dispatcher.sv
// tb/tb_brick_dispatcher.sv - randomized self-checking bench for brick_dispatcher

module tb_brick_dispatcher;

    logic         clk = 1'b0;
    logic         rst;
    logic         brick_valid;
    logic [255:0] brick_data;
    logic [63:0]  brick_off;
    logic         brick_ack;
    logic         nz_valid;
    logic         nz_ready;
    logic [15:0]  nz_data;
    logic [3:0]   nz_off;
    logic         nz_last;
    logic [4:0]   nz_count;
    logic         brick_done;

    int checks   = 0;
    int failures = 0;

    brick_dispatcher dut (
        .clk         (clk),
        .rst         (rst),
        .brick_valid (brick_valid),
        .brick_data  (brick_data),
        .brick_off   (brick_off),
        .brick_ack   (brick_ack),
        .nz_valid    (nz_valid),
        .nz_ready    (nz_ready),
        .nz_data     (nz_data),
        .nz_off      (nz_off),
        .nz_last     (nz_last),
        .nz_count    (nz_count),
        .brick_done  (brick_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    // 0: ready tied high, 1: pattern 1,0,0,1,0,1 repeating, 2: random
    function automatic logic pick_ready(input int mode, input int cyc);
        logic [5:0] pat;
        pat = 6'b101001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[(cyc - 1) % 6];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Dispatch one brick and compare every cycle against the queue of expected pairs
    task automatic run_brick(input logic [255:0] d, input logic [63:0] o, input int mode, input int hold);
        logic [19:0] exp_q[$];
        logic [19:0] front;
        int   cnt;
        int   cyc;
        int   last_acc;
        int   acc;
        bit   stop;
        bit   done_seen;
        bit   stalled;
        logic [15:0] prev_data;
        logic [3:0]  prev_off;
        logic        prev_last;

        cnt  = 0;
        stop = 0;
        for (int k = 0; k < 16; k++) begin
            if (!stop && d[16*k +: 16] != 16'd0) begin
                exp_q.push_back({d[16*k +: 16], o[4*k +: 4]});
                cnt++;
            end else begin
                stop = 1;
            end
        end

        @(posedge clk); #1;
        brick_data  = d;
        brick_off   = o;
        brick_valid = 1'b1;
        nz_ready    = 1'b0;
        @(posedge clk); #1;
        brick_data  = rand_data();
        brick_off   = {$urandom, $urandom};
        cyc         = 1;
        nz_ready    = pick_ready(mode, cyc);
        last_acc    = (cnt == 0) ? 0 : -100;
        acc         = 0;
        done_seen   = 0;
        stalled     = 0;
        prev_data   = '0;
        prev_off    = '0;
        prev_last   = 1'b0;

        while (cyc < 200 && !done_seen) begin
            @(negedge clk);
            check("brick_ack", brick_ack, (cyc == 1));
            check("nz_count", nz_count, cnt);
            if (nz_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    front = exp_q[0];
                    check("nz_data", nz_data, front[19:4]);
                    check("nz_off", nz_off, front[3:0]);
                    check("nz_last", nz_last, (exp_q.size() == 1));
                    if (stalled) begin
                        check("stall_data", nz_data, prev_data);
                        check("stall_off", nz_off, prev_off);
                        check("stall_last", nz_last, prev_last);
                    end
                    if (nz_ready) begin
                        void'(exp_q.pop_front());
                        acc++;
                        last_acc = cyc;
                        stalled  = 0;
                    end else begin
                        stalled   = 1;
                        prev_data = nz_data;
                        prev_off  = nz_off;
                        prev_last = nz_last;
                    end
                end
            end else begin
                check("valid_dropped", stalled, 0);
            end
            if (brick_done) begin
                check("done_cycle", cyc, last_acc + 1);
                check("done_no_valid", nz_valid, 0);
                done_seen = 1;
            end
            @(posedge clk); #1;
            cyc++;
            nz_ready = pick_ready(mode, cyc);
        end
        check("done_seen", done_seen, 1);
        check("accepted", acc, cnt);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_quiet", {brick_ack, nz_valid, brick_done}, 3'b000);
            @(posedge clk); #1;
        end
        brick_valid = 1'b0;
        @(negedge clk);
        check("post_done_quiet", {brick_ack, nz_valid, brick_done}, 3'b000);
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [255:0] seq_data();
        logic [255:0] d;
        for (int k = 0; k < 16; k++) d[16*k +: 16] = 16'(k + 1);
        return d;
    endfunction

    function automatic logic [63:0] seq_off();
        logic [63:0] o;
        for (int k = 0; k < 16; k++) o[4*k +: 4] = 4'(k);
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        logic [63:0]  o;
        int           p;

        rst         = 1'b1;
        brick_valid = 1'b0;
        brick_data  = '0;
        brick_off   = '0;
        nz_ready    = 1'b0;

        // Reset held with random inputs: everything stays zero
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            brick_valid = 1'($urandom_range(0, 1));
            brick_data  = rand_data();
            brick_off   = {$urandom, $urandom};
            nz_ready    = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_outputs", {brick_ack, nz_valid, nz_last, brick_done, nz_count, nz_off, nz_data},
                  32'd0);
        end
        @(posedge clk); #1;
        rst         = 1'b0;
        brick_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_outputs", {brick_ack, nz_valid, nz_last, brick_done, nz_count, nz_off, nz_data},
                  32'd0);
        end

        // Full brick, ready tied high
        run_brick(seq_data(), seq_off(), 0, 0);

        // Sparse brick with garbage after the first zero
        d = '0;
        o = {$urandom, $urandom};
        d[15:0]   = 16'h000A; o[3:0]   = 4'd2;
        d[31:16]  = 16'h000B; o[7:4]   = 4'd7;
        d[47:32]  = 16'h000C; o[11:8]  = 4'd15;
        d[95:80]  = 16'h5555;
        run_brick(d, o, 0, 0);

        // All-zero brick
        run_brick('0, {$urandom, $urandom}, 0, 0);

        // Backpressure pattern
        run_brick(seq_data(), seq_off(), 1, 0);

        // Flag held high long after done, then a new brick
        run_brick(seq_data(), seq_off(), 0, 40);
        d = rand_data();
        for (int k = 0; k < 16; k++) if (d[16*k +: 16] == 16'd0) d[16*k +: 16] = 16'h1234;
        run_brick(d, {$urandom, $urandom}, 2, 5);

        // Reset during beat 5 aborts the brick
        @(posedge clk); #1;
        brick_data  = seq_data();
        brick_off   = seq_off();
        brick_valid = 1'b1;
        nz_ready    = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
        end
        check("beat5_data", nz_data, 16'd5);
        rst         = 1'b1;
        brick_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_quiet", {nz_valid, brick_done, nz_count}, 7'd0);
        end
        run_brick(seq_data(), seq_off(), 0, 0);

        // Random bricks with random first-zero position and random backpressure
        for (int n = 0; n < 12; n++) begin
            d = rand_data();
            p = $urandom_range(0, 16);
            for (int k = 0; k < 16; k++) begin
                if (k < p && d[16*k +: 16] == 16'd0) d[16*k +: 16] = 16'h0001;
                if (k == p) d[16*k +: 16] = 16'd0;
            end
            run_brick(d, {$urandom, $urandom}, 2, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
